disp_hex_mux_n: RTL
===================

// Module: disp_hex_mux_n
// PURPOSE
//   N-digit time-multiplexed hex display driver for common-anode 7-seg banks.
//   Decodes a packed hex word, latches new values only at frame boundaries,
//   and adds optional leading-zero blanking and PWM brightness control.
//   Replaces the fixed 4-digit decoder + mux pairing in board-level test tops.
// PARAMETERS
//   N_DIG       4   number of digits (2..8)
//   DWELL_BITS  16  digit dwell time = 2**DWELL_BITS clk cycles
//   BRIGHT_BITS 4   brightness resolution (BRIGHT_BITS <= DWELL_BITS)
// PORTS
//   clk        in   1              system clock
//   reset_n    in   1              asynchronous reset, active-low
//   load       in   1              1-cycle strobe: capture hex_in/dp_in into pending
//   hex_in     in   4*N_DIG        digit i = hex_in[4i+3:4i]; digit 0 = rightmost
//   dp_in      in   N_DIG          1 = decimal point of digit i lit
//   lz_en      in   1              1 = blank leading zero digits
//   bright     in   BRIGHT_BITS    duty level; 0 = dark
//   an         out  N_DIG          anode enables, active-low
//   sseg       out  8              {dp,g,f,e,d,c,b,a}, active-low
//   pend       out  1              1 = pending value not yet displayed
//   frame_tick out  1              1-cycle pulse at each frame start
// BEHAVIOUR
//   Reset (async, reset_n=0): cnt=0, idx=0, shadow=0, pending=0, pend=0,
//     an=all 1, sseg=8'hFF, frame_tick=0. Counting resumes on the first edge after release.
//   cnt: DWELL_BITS-bit free-running counter; at cnt=all ones, idx advances;
//     idx wraps N_DIG-1 -> 0. Frame = N_DIG * 2**DWELL_BITS cycles.
//   frame_tick: asserted in the cycle after idx wraps N_DIG-1 -> 0.
//   load=1: hex_in/dp_in -> pending regs, pend=1 next cycle; a later load
//     before apply overwrites pending (last value wins).
//   Apply: on the clk edge where idx wraps to 0 with pend=1, pending -> shadow,
//     pend -> 0. Load and wrap in same cycle: the new load is captured into
//     pending, the old pending is applied, pend stays 1.
//   Decode (shadow digit idx): standard hex glyphs 0-9,A,b,C,d,E,F, identical
//     to hex_to_sseg; e.g. 0 -> sseg[6:0]=7'b1000000, 8 -> 7'b0000000.
//   Blank: lz_en=1 and digits N_DIG-1..i of shadow all zero and i!=0 ->
//     sseg[6:0]=7'h7F; dp follows dp_in regardless. Digit 0 never blanked.
//   sseg[7] = ~shadow_dp[idx].
//   PWM: lit = (cnt[DWELL_BITS-1 -: BRIGHT_BITS] < bright); an = lit ?
//     ~(1<<idx) : all 1. bright=2**BRIGHT_BITS-1 gives (2**B-1)/2**B duty.
//   an and sseg registered: one cycle of latency after idx/cnt; both change
//     on the same edge, so no cross-digit ghosting.
//   lz_en and bright are sampled live (not shadowed).
// TESTING  (N_DIG=4, DWELL_BITS=4, BRIGHT_BITS=2)
//   reset_n=0 mid-frame -> an=4'b1111, sseg=8'hFF, pend=0 immediately (async);
//     after release an cycles 1110,1101,1011,0111 at 16 clks/digit, bright=3.
//   load hex_in=16'h12AF, dp_in=4'b0100 at idx=1 -> pend=1 until next
//     wrap; next frame digit0 sseg=8'b10001110 (F), digit2 sseg[7]=0.
//   two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed,
//     1111 never appears on sseg.
//   lz_en=1, shadow=16'h0030 -> digits 3,2 sseg[6:0]=7'h7F, digit1 '3',
//     digit0 '0'; shadow=16'h0000 -> only digit 0 lit, showing '0'.
//   bright=0 -> an=4'b1111 always; bright=2 -> an active 8 of 16 dwell clks.
//   load coincident with idx wrap -> old pending applied, new held, pend=1,
//     new value applied at the following wrap; frame_tick pulses once/frame.

Source files
------------

// File: rtl/disp_hex_mux_n.sv
// disp_hex_mux_n
//   N-digit time-multiplexed hex display driver for common-anode 7-segment
//   banks. A packed hex word is captured into pending registers on a load
//   strobe. It is then moved into the displayed shadow copy only at a frame
//   boundary, so a digit never changes partway through a refresh frame.
//   Optional leading-zero blanking and PWM brightness are applied to the
//   shadow copy while it is on display.
//
// Parameters
//   N_DIG       number of digits (2..8)
//   DWELL_BITS  each digit is on for 2**DWELL_BITS clk cycles
//   BRIGHT_BITS brightness resolution (BRIGHT_BITS <= DWELL_BITS)
//
// Ports
//   clk        system clock
//   reset_n    asynchronous reset, active-low
//   load       1-cycle strobe: capture hex_in/dp_in into pending
//   hex_in     digit i = hex_in[4i+3:4i]; digit 0 is the rightmost
//   dp_in      1 = decimal point of digit i lit
//   lz_en      1 = blank leading zero digits (sampled live)
//   bright     duty level, 0 = dark (sampled live)
//   an         anode enables, active-low, registered
//   sseg       {dp,g,f,e,d,c,b,a}, active-low, registered
//   pend       1 = pending value not yet displayed
//   frame_tick 1-cycle pulse at each frame start
module disp_hex_mux_n #(
  parameter int N_DIG       = 4,
  parameter int DWELL_BITS  = 16,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [4*N_DIG-1:0]     hex_in,
  input  logic [N_DIG-1:0]       dp_in,
  input  logic                   lz_en,
  input  logic [BRIGHT_BITS-1:0] bright,
  output logic [N_DIG-1:0]       an,
  output logic [7:0]             sseg,
  output logic                   pend,
  output logic                   frame_tick
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N_DIG - 1);

  logic [DWELL_BITS-1:0] cnt;
  idx_t                  idx;
  logic                  dwell_end;
  logic                  wrap;

  logic [4*N_DIG-1:0]    pend_hex;
  logic [N_DIG-1:0]      pend_dp;
  logic [4*N_DIG-1:0]    shadow_hex;
  logic [N_DIG-1:0]      shadow_dp;

  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIG-1:0]      cur_sel;
  logic                  zero_run;
  logic [BRIGHT_BITS-1:0] duty_slice;
  logic                  lit;
  logic [N_DIG-1:0]      an_next;
  logic [7:0]            sseg_next;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign dwell_end = &cnt;
  assign wrap      = dwell_end && (idx == LAST_IDX);

  // Dwell counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      frame_tick <= wrap;
      if (dwell_end) begin
        if (idx == LAST_IDX) idx <= '0;
        else                 idx <= idx + 1'b1;
      end
    end
  end

  // Pending/shadow double buffer. When a load meets a wrap, the old pending
  // value is applied and the new one is kept pending for the next wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_hex   <= '0;
      pend_dp    <= '0;
      shadow_hex <= '0;
      shadow_dp  <= '0;
      pend       <= 1'b0;
    end else begin
      if (load) begin
        pend_hex <= hex_in;
        pend_dp  <= dp_in;
      end
      if (wrap && pend) begin
        shadow_hex <= pend_hex;
        shadow_dp  <= pend_dp;
      end
      if (load)      pend <= 1'b1;
      else if (wrap) pend <= 1'b0;
    end
  end

  // Select the active digit and work out leading-zero blanking. The loop walks
  // from the most significant digit down, so zero_run is still set at digit i
  // only if every digit from N_DIG-1 down to i is zero.
  always_comb begin
    cur_hex   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    zero_run  = 1'b1;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      int unsigned i;
      i = N_DIG - 1 - k;
      zero_run = zero_run && (shadow_hex[4*i +: 4] == 4'h0);
      if (idx == idx_t'(i)) begin
        cur_hex    = shadow_hex[4*i +: 4];
        cur_dp     = shadow_dp[i];
        cur_blank  = zero_run && (i != 0);
        cur_sel[i] = 1'b1;
      end
    end
  end

  // PWM: the digit is driven only for the first bright/2**BRIGHT_BITS of its dwell.
  assign duty_slice = cnt[DWELL_BITS-1 -: BRIGHT_BITS];
  assign lit        = duty_slice < bright;

  always_comb begin
    an_next   = lit ? ~cur_sel : '1;
    sseg_next = {~cur_dp, (lz_en && cur_blank) ? 7'h7F : hex_glyph(cur_hex)};
  end

  // an and sseg are updated on the same edge so that segments never leak
  // onto the neighbouring digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule
